// File: rtl/decode_stage.sv
// Decode stage: field decode, 16-entry register file with write-back port, D/E pipeline register.
// Latency: InstrD/PCD decoded values appear on the *E outputs one clk after they are presented.
// Backpressure: StallE holds the D/E register and FlushE loads a bubble (flush wins); register file writes never stall.
//
// Ports:
//   clk, reset (async, active-low)
//   InstrD, PCD                      instruction and its PC from the F/D register
//   StallE, FlushE                   hazard-unit controls for the D/E register
//   RegWriteW, RdW, ResultW          register file write-back port
//   Rs1D, Rs2D                       combinational source indices for the hazard unit
//   *E                               registered controls, operands, immediate, indices and PC for execute
module decode_stage #(
  parameter int DATA_W  = 24,
  parameter int INSTR_W = 20,
  parameter int PC_W    = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic               RegWriteW,
  input  logic [3:0]         RdW,
  input  logic [DATA_W-1:0]  ResultW,
  output logic [3:0]         Rs1D,
  output logic [3:0]         Rs2D,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               MemToRegE,
  output logic               BranchE,
  output logic               BranchNeE,
  output logic               JumpE,
  output logic               ALUSrcE,
  output logic               IllegalE,
  output logic [2:0]         ALUControlE,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [3:0]         Rs1E,
  output logic [3:0]         Rs2E,
  output logic [3:0]         RdE,
  output logic [PC_W-1:0]    PCE
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // D/E pipeline register contents
  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic              branch_ne;
    logic              jump;
    logic              alu_src;
    logic              illegal;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [3:0]        rd;
    logic [PC_W-1:0]   pc;
  } de_t;

  de_t de_d;
  de_t de_q;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm8_ext;
  logic [DATA_W-1:0] imm16_ext;
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] rd1_rd;
  logic [DATA_W-1:0] rd2_rd;

  assign op        = InstrD[19:16];
  assign imm8_ext  = {{(DATA_W-8){InstrD[7]}}, InstrD[7:0]};
  assign imm16_ext = {{(DATA_W-16){InstrD[15]}}, InstrD[15:0]};

  // Field decode. Any field the format does not use stays 0 so the hazard
  // unit never sees a false dependency on a stale index.
  always_comb begin
    de_d = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        de_d.reg_write = 1'b1;
        de_d.rd        = InstrD[15:12];
        de_d.rs1       = InstrD[11:8];
        de_d.rs2       = InstrD[7:4];
        case (op)
          OP_SUB:  de_d.alu_ctrl = ALU_SUB;
          OP_AND:  de_d.alu_ctrl = ALU_AND;
          OP_OR:   de_d.alu_ctrl = ALU_OR;
          default: de_d.alu_ctrl = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_LDR: begin
        de_d.reg_write  = 1'b1;
        de_d.mem_to_reg = (op == OP_LDR);
        de_d.alu_src    = 1'b1;
        de_d.alu_ctrl   = ALU_ADD;
        de_d.rd         = InstrD[15:12];
        de_d.rs1        = InstrD[11:8];
        de_d.imm        = imm8_ext;
      end
      OP_STR: begin
        de_d.mem_write = 1'b1;
        de_d.alu_src   = 1'b1;
        de_d.alu_ctrl  = ALU_ADD;
        de_d.rs2       = InstrD[15:12];
        de_d.rs1       = InstrD[11:8];
        de_d.imm       = imm8_ext;
      end
      OP_BEQ, OP_BNE: begin
        de_d.branch    = 1'b1;
        de_d.branch_ne = (op == OP_BNE);
        de_d.alu_ctrl  = ALU_SUB;
        de_d.rs1       = InstrD[15:12];
        de_d.rs2       = InstrD[11:8];
        de_d.imm       = imm8_ext;
      end
      OP_JMP: begin
        de_d.jump = 1'b1;
        de_d.imm  = imm16_ext;
      end
      OP_NOP: ;
      default: de_d.illegal = 1'b1;
    endcase
    de_d.rd1 = rd1_rd;
    de_d.rd2 = rd2_rd;
    de_d.pc  = PCD;
  end

  // Source indices leave before the register so the hazard unit can act this cycle.
  always_comb begin
    Rs1D = 4'h0;
    Rs2D = 4'h0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        Rs1D = InstrD[11:8];
        Rs2D = InstrD[7:4];
      end
      OP_ADDI, OP_LDR: Rs1D = InstrD[11:8];
      OP_STR: begin
        Rs1D = InstrD[11:8];
        Rs2D = InstrD[15:12];
      end
      OP_BEQ, OP_BNE: begin
        Rs1D = InstrD[15:12];
        Rs2D = InstrD[11:8];
      end
      default: ;
    endcase
  end

  // Register file; r0 is never written and always reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (RegWriteW && (RdW != 4'h0)) begin
      rf[RdW] <= ResultW;
    end
  end

  // Write-through bypass: a same-cycle write-back is visible to decode, so the
  // write-back stage needs no separate forwarding path into decode.
  always_comb begin
    if (de_d.rs1 == 4'h0)                      rd1_rd = '0;
    else if (RegWriteW && (RdW == de_d.rs1))   rd1_rd = ResultW;
    else                                       rd1_rd = rf[de_d.rs1];
    if (de_d.rs2 == 4'h0)                      rd2_rd = '0;
    else if (RegWriteW && (RdW == de_d.rs2))   rd2_rd = ResultW;
    else                                       rd2_rd = rf[de_d.rs2];
  end

  // D/E register: flush beats stall beats load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       de_q <= '0;
    else if (FlushE)  de_q <= '0;
    else if (!StallE) de_q <= de_d;
  end

  assign RegWriteE   = de_q.reg_write;
  assign MemWriteE   = de_q.mem_write;
  assign MemToRegE   = de_q.mem_to_reg;
  assign BranchE     = de_q.branch;
  assign BranchNeE   = de_q.branch_ne;
  assign JumpE       = de_q.jump;
  assign ALUSrcE     = de_q.alu_src;
  assign IllegalE    = de_q.illegal;
  assign ALUControlE = de_q.alu_ctrl;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ImmExtE     = de_q.imm;
  assign Rs1E        = de_q.rs1;
  assign Rs2E        = de_q.rs2;
  assign RdE         = de_q.rd;
  assign PCE         = de_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [19:0] InstrD;
  logic [14:0] PCD;
  logic        StallE, FlushE, RegWriteW;
  logic [3:0]  RdW;
  logic [23:0] ResultW;
  logic [3:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, MemToRegE, BranchE, BranchNeE, JumpE, ALUSrcE, IllegalE;
  logic [2:0]  ALUControlE;
  logic [23:0] RD1E, RD2E, ImmExtE;
  logic [3:0]  Rs1E, Rs2E, RdE;
  logic [14:0] PCE;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD),
    .StallE(StallE), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
    .BranchE(BranchE), .BranchNeE(BranchNeE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .IllegalE(IllegalE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  // ctrl = {RegWrite,MemWrite,MemToReg,Branch,BranchNe,Jump,ALUSrc,Illegal,ALUControl}
  localparam logic [10:0] C_RW  = 11'h400;
  localparam logic [10:0] C_MW  = 11'h200;
  localparam logic [10:0] C_M2R = 11'h100;
  localparam logic [10:0] C_BR  = 11'h080;
  localparam logic [10:0] C_BNE = 11'h040;
  localparam logic [10:0] C_J   = 11'h020;
  localparam logic [10:0] C_SRC = 11'h010;
  localparam logic [10:0] C_ILL = 11'h008;

  typedef struct packed {
    logic [10:0] ctrl;
    logic [23:0] rd1;
    logic [23:0] rd2;
    logic [23:0] imm;
    logic [11:0] idx;
    logic [14:0] pc;
    logic        chk_imm;
    logic        chk_pc;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  function automatic exp_t mk(input logic [10:0] ctrl, input logic [23:0] rd1, input logic [23:0] rd2,
                              input logic [23:0] imm, input logic [11:0] idx, input logic [14:0] pc,
                              input logic chk_imm, input logic chk_pc);
    exp_t e;
    e.ctrl = ctrl; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.idx = idx; e.pc = pc; e.chk_imm = chk_imm; e.chk_pc = chk_pc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input exp_t e);
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic check_now();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard: observed empty queue, expected a pending entry");
    end else begin
      e = sb.pop_front();
      t = tq.pop_front();
      chk({t, ".ctrl"}, 32'({RegWriteE, MemWriteE, MemToRegE, BranchE, BranchNeE, JumpE,
                             ALUSrcE, IllegalE, ALUControlE}), 32'(e.ctrl));
      chk({t, ".rd1"}, 32'(RD1E), 32'(e.rd1));
      chk({t, ".rd2"}, 32'(RD2E), 32'(e.rd2));
      if (e.chk_imm) chk({t, ".imm"}, 32'(ImmExtE), 32'(e.imm));
      chk({t, ".idx"}, 32'({Rs1E, Rs2E, RdE}), 32'(e.idx));
      if (e.chk_pc) chk({t, ".pc"}, 32'(PCE), 32'(e.pc));
    end
  endtask

  task automatic cycle_check();
    @(posedge clk);
    #1;
    check_now();
  endtask

  exp_t zero_e;
  exp_t add32_e;

  initial begin
    reset = 1'b0; InstrD = '0; PCD = '0; StallE = 1'b0; FlushE = 1'b0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    zero_e = mk(11'h0, 24'h0, 24'h0, 24'h0, 12'h0, 15'h0, 1'b1, 1'b1);

    // Reset state
    #1;
    push("reset_state", zero_e);
    check_now();
    chk("reset_rs1d", 32'(Rs1D), 32'h0);

    @(negedge clk);
    reset = 1'b1;

    // Fill r1..r15 with distinct values
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      RegWriteW = 1'b1; RdW = 4'(i); ResultW = 24'h010000 | 24'(i); InstrD = '0;
    end
    @(negedge clk);
    RegWriteW = 1'b0; InstrD = 20'h11230; PCD = 15'h0007;
    push("prefill_add", mk(C_RW, 24'h010002, 24'h010003, 24'h0, {4'h2, 4'h3, 4'h1}, 15'h0007, 1'b0, 1'b1));
    cycle_check();

    // Async reset with D/E full and a write in flight
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 4'h5; ResultW = 24'hDEAD00;
    reset = 1'b0;
    push("async_reset", zero_e);
    #1;
    check_now();
    @(posedge clk);
    @(negedge clk);
    RegWriteW = 1'b0;
    reset = 1'b1;

    // r1..r15 read zero after reset
    for (int i = 1; i < 16; i++) begin
      logic [3:0] r;
      r = 4'(i);
      @(negedge clk);
      InstrD = {4'h1, 4'h0, r, r, 4'h0}; PCD = 15'h0100 + 15'(i);
      push($sformatf("rf_clear_r%0d", i), mk(C_RW, 24'h0, 24'h0, 24'h0, {r, r, 4'h0}, 15'h0100 + 15'(i), 1'b0, 1'b1));
      cycle_check();
    end

    // r2=5, r3=7, then R-type ops
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 4'h2; ResultW = 24'd5; InstrD = '0;
    @(negedge clk);
    RdW = 4'h3; ResultW = 24'd7;
    @(negedge clk);
    RegWriteW = 1'b0; InstrD = 20'h11230; PCD = 15'h0020;
    push("add", mk(C_RW, 24'd5, 24'd7, 24'h0, {4'h2, 4'h3, 4'h1}, 15'h0020, 1'b0, 1'b1));
    cycle_check();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      InstrD = {4'(k + 1), 16'h1230}; PCD = 15'h0020 + 15'(k);
      push($sformatf("rtype_op%0d", k + 1), mk(C_RW | 11'(k), 24'd5, 24'd7, 24'h0, {4'h2, 4'h3, 4'h1},
                                              15'h0020 + 15'(k), 1'b0, 1'b1));
      cycle_check();
    end

    // ADDI with same-cycle write-back bypass
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 4'h4; ResultW = 24'h00ABCD; InstrD = 20'h51480; PCD = 15'h0030;
    push("addi_bypass", mk(C_RW | C_SRC, 24'h00ABCD, 24'h0, 24'hFFFF80, {4'h4, 4'h0, 4'h1}, 15'h0030, 1'b1, 1'b1));
    cycle_check();
    @(negedge clk);
    RegWriteW = 1'b0; InstrD = 20'h61400; PCD = 15'h0031;
    push("ldr", mk(C_RW | C_M2R | C_SRC, 24'h00ABCD, 24'h0, 24'h0, {4'h4, 4'h0, 4'h1}, 15'h0031, 1'b1, 1'b1));
    cycle_check();
    @(negedge clk);
    InstrD = 20'h723FF; PCD = 15'h0032;
    push("str", mk(C_MW | C_SRC, 24'd7, 24'd5, 24'hFFFFFF, {4'h3, 4'h2, 4'h0}, 15'h0032, 1'b1, 1'b1));
    cycle_check();
    @(negedge clk);
    InstrD = 20'h82310; PCD = 15'h0033;
    #1;
    chk("beq_rs1d", 32'(Rs1D), 32'h2);
    chk("beq_rs2d", 32'(Rs2D), 32'h3);
    push("beq", mk(C_BR | 11'h001, 24'd5, 24'd7, 24'h000010, {4'h2, 4'h3, 4'h0}, 15'h0033, 1'b1, 1'b1));
    cycle_check();
    @(negedge clk);
    InstrD = 20'h9237F; PCD = 15'h0034;
    push("bne", mk(C_BR | C_BNE | 11'h001, 24'd5, 24'd7, 24'h00007F, {4'h2, 4'h3, 4'h0}, 15'h0034, 1'b1, 1'b1));
    cycle_check();

    // Stall + flush together -> bubble; r7 written during the flush
    @(negedge clk);
    StallE = 1'b1; FlushE = 1'b1; InstrD = 20'h21230; PCD = 15'h0040;
    RegWriteW = 1'b1; RdW = 4'h7; ResultW = 24'h000777;
    push("stall_flush", zero_e);
    cycle_check();
    @(negedge clk);
    StallE = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; InstrD = 20'h11230; PCD = 15'h0041;
    add32_e = mk(C_RW, 24'd5, 24'd7, 24'h0, {4'h2, 4'h3, 4'h1}, 15'h0041, 1'b0, 1'b1);
    push("pre_stall", add32_e);
    cycle_check();
    // Stall 3 cycles with changing InstrD; r6 written during the first
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      StallE = 1'b1; InstrD = (k == 1) ? 20'hA0010 : 20'h723FF; PCD = 15'h0050 + 15'(k);
      RegWriteW = (k == 0); RdW = 4'h6; ResultW = 24'h000666;
      push($sformatf("stall_hold%0d", k), add32_e);
      cycle_check();
    end
    @(negedge clk);
    StallE = 1'b0; RegWriteW = 1'b0; InstrD = 20'h41670; PCD = 15'h0060;
    push("post_stall_or", mk(C_RW | 11'h003, 24'h000666, 24'h000777, 24'h0, {4'h6, 4'h7, 4'h1}, 15'h0060, 1'b0, 1'b1));
    cycle_check();
    @(negedge clk);
    FlushE = 1'b1; InstrD = 20'h11230; PCD = 15'h0061;
    push("flush_only", zero_e);
    cycle_check();
    FlushE = 1'b0;

    // Write to r0 is ignored, no bypass
    @(negedge clk);
    RegWriteW = 1'b1; RdW = 4'h0; ResultW = 24'h123456; InstrD = 20'h11000; PCD = 15'h0070;
    push("r0_write_bypass", mk(C_RW, 24'h0, 24'h0, 24'h0, {4'h0, 4'h0, 4'h1}, 15'h0070, 1'b0, 1'b1));
    cycle_check();
    @(negedge clk);
    RegWriteW = 1'b0; PCD = 15'h0071;
    push("r0_read", mk(C_RW, 24'h0, 24'h0, 24'h0, {4'h0, 4'h0, 4'h1}, 15'h0071, 1'b0, 1'b1));
    cycle_check();

    // Illegal and jumps
    @(negedge clk);
    InstrD = 20'hF0000; PCD = 15'h0080;
    push("illegal", mk(C_ILL, 24'h0, 24'h0, 24'h0, 12'h0, 15'h0080, 1'b0, 1'b0));
    cycle_check();
    @(negedge clk);
    InstrD = 20'hA0010; PCD = 15'h0081;
    #1;
    chk("jmp_rs1d", 32'(Rs1D), 32'h0);
    chk("jmp_rs2d", 32'(Rs2D), 32'h0);
    push("jmp_fwd", mk(C_J, 24'h0, 24'h0, 24'h000010, 12'h0, 15'h0081, 1'b1, 1'b1));
    cycle_check();
    @(negedge clk);
    InstrD = 20'hA8000; PCD = 15'h7FFF;
    push("jmp_back", mk(C_J, 24'h0, 24'h0, 24'hFF8000, 12'h0, 15'h7FFF, 1'b1, 1'b1));
    cycle_check();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
